// File: rtl/slow_adc_telemetry.sv
// Four-channel slow-ADC EMA smoother with ch0/1 peak hold (SLOW_ADC_TELEMETRY_PEAK_EN) and ch2 hysteretic alarm.
// Latency: tick -> tlm_valid in 6 cycles; a snapshot that is not accepted blocks newer ones, which are dropped and flag overrun.
module slow_adc_telemetry #(
    parameter int SAMPLE_DIV = 1536,
    parameter int AVG_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ain0,
    input  logic [11:0] ain1,
    input  logic [11:0] ain2,
    input  logic [11:0] ain3,
    input  logic [11:0] thr_hi,
    input  logic [11:0] thr_lo,
    output logic [11:0] avg0,
    output logic [11:0] avg1,
    output logic [11:0] avg2,
    output logic [11:0] avg3,
    output logic [11:0] peak0,
    output logic [11:0] peak1,
    output logic        alarm,
    output logic        tlm_valid,
    input  logic        tlm_ready,
    output logic        overrun
);

    localparam int ACC_W = 12 + AVG_SHIFT;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {IDLE, CH0, CH1, CH2, CH3, SNAP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0][11:0]       sh_q, sh_d;
    logic [3:0][ACC_W-1:0]  acc_q, acc_d;
    logic [3:0][11:0]       avg_q, avg_d;
    logic                   primed_q, primed_d;
    logic                   alarm_q, alarm_d;
    logic                   vld_q, vld_d;
    logic                   ovr_q, ovr_d;

    logic                   tick;
    logic                   hs;
    logic                   snap_load;
    logic                   ch_act;
    logic [1:0]             ch;
    logic [11:0]            smp;
    logic [ACC_W-1:0]       acc_cur;
    logic [ACC_W-1:0]       acc_new;
    logic [11:0]            avg_new;

    assign tick      = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign hs        = vld_q & tlm_ready;
    assign snap_load = (state_q == SNAP) && (!vld_q || tlm_ready);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ch      = 2'd0;
        ch_act  = 1'b0;
        case (state_q)
            IDLE: if (tick) state_d = CH0;
            CH0:  begin ch = 2'd0; ch_act = 1'b1; state_d = CH1;  end
            CH1:  begin ch = 2'd1; ch_act = 1'b1; state_d = CH2;  end
            CH2:  begin ch = 2'd2; ch_act = 1'b1; state_d = CH3;  end
            CH3:  begin ch = 2'd3; ch_act = 1'b1; state_d = SNAP; end
            SNAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single EMA datapath shared by all channels, steered by the FSM state.
    always_comb begin
        smp     = sh_q[ch];
        acc_cur = acc_q[ch];
        if (primed_q)
            acc_new = acc_cur - (acc_cur >> AVG_SHIFT) + {{AVG_SHIFT{1'b0}}, smp};
        else
            acc_new = {smp, {AVG_SHIFT{1'b0}}};
        avg_new = acc_new[ACC_W-1:AVG_SHIFT];
    end

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        sh_d     = tick ? {ain3, ain2, ain1, ain0} : sh_q;
        acc_d    = acc_q;
        avg_d    = avg_q;
        primed_d = primed_q | (state_q == SNAP);
        alarm_d  = alarm_q;
        vld_d    = hs ? 1'b0 : vld_q;
        ovr_d    = ovr_q;

        if (ch_act) acc_d[ch] = acc_new;

        // Set is tested first so it wins when the thresholds overlap.
        if (state_q == CH2) begin
            if (avg_new >= thr_hi)      alarm_d = 1'b1;
            else if (avg_new <= thr_lo) alarm_d = 1'b0;
        end

        if (state_q == SNAP) begin
            if (snap_load) begin
                for (int i = 0; i < 4; i++) avg_d[i] = acc_q[i][ACC_W-1:AVG_SHIFT];
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            avg_q    <= '0;
            primed_q <= 1'b0;
            alarm_q  <= 1'b0;
            vld_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            avg_q    <= avg_d;
            primed_q <= primed_d;
            alarm_q  <= alarm_d;
            vld_q    <= vld_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef SLOW_ADC_TELEMETRY_PEAK_EN
    logic [1:0][11:0] pk_q, pk_d;
    logic [1:0][11:0] pko_q, pko_d;

    // A clear coinciding with a channel update leaves that sample as the new peak.
    always_comb begin
        pk_d  = hs ? '0 : pk_q;
        pko_d = snap_load ? pk_q : pko_q;
        if (state_q == CH0) pk_d[0] = (hs || smp > pk_q[0]) ? smp : pk_q[0];
        if (state_q == CH1) pk_d[1] = (hs || smp > pk_q[1]) ? smp : pk_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_q  <= '0;
            pko_q <= '0;
        end else begin
            pk_q  <= pk_d;
            pko_q <= pko_d;
        end
    end

    assign peak0 = pko_q[0];
    assign peak1 = pko_q[1];
`else
    assign peak0 = avg_q[0];
    assign peak1 = avg_q[1];
`endif

    assign avg0      = avg_q[0];
    assign avg1      = avg_q[1];
    assign avg2      = avg_q[2];
    assign avg3      = avg_q[3];
    assign alarm     = alarm_q;
    assign tlm_valid = vld_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_slow_adc_telemetry.sv
// Directed bench for slow_adc_telemetry: preload, EMA steps, alarm hysteresis, overrun, peak hold, mid-round reset.
module tb_slow_adc_telemetry;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ain0, ain1, ain2, ain3, thr_hi, thr_lo;
    logic [11:0] avg0, avg1, avg2, avg3, peak0, peak1;
    logic        alarm, tlm_valid, tlm_ready, overrun;

    int n_vec = 0;
    int n_err = 0;

    slow_adc_telemetry #(.SAMPLE_DIV(16), .AVG_SHIFT(3)) dut (
        .clk(clk), .rst(rst),
        .ain0(ain0), .ain1(ain1), .ain2(ain2), .ain3(ain3),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .avg0(avg0), .avg1(avg1), .avg2(avg2), .avg3(avg3),
        .peak0(peak0), .peak1(peak1), .alarm(alarm),
        .tlm_valid(tlm_valid), .tlm_ready(tlm_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        tlm_ready = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic ack();
        tlm_ready = 1'b1;
        cyc(1);
        tlm_ready = 1'b0;
    endtask

    task automatic wait_snap(output int n);
        n = 0;
        while (tlm_valid !== 1'b1 && n < 60) begin
            cyc(1);
            n++;
        end
        check_val("snap_seen", 12'(tlm_valid), 12'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rst_valid"},   12'(tlm_valid), 12'h0);
        check_val({tag, "_rst_overrun"}, 12'(overrun),   12'h0);
        check_val({tag, "_rst_alarm"},   12'(alarm),     12'h0);
        check_val({tag, "_rst_avg0"},    avg0,           12'h000);
        check_val({tag, "_rst_avg2"},    avg2,           12'h000);
        check_val({tag, "_rst_peak0"},   peak0,          12'h000);
    endtask

    task automatic check_preload(input string tag);
        int n;
        wait_snap(n);
        check_val({tag, "_latency"}, 12'(n), 12'd21);
        check_val({tag, "_avg0"},    avg0,   12'h800);
        check_val({tag, "_avg1"},    avg1,   12'h400);
        check_val({tag, "_avg2"},    avg2,   12'h200);
        check_val({tag, "_avg3"},    avg3,   12'h100);
        check_val({tag, "_peak0"},   peak0,  12'h800);
        check_val({tag, "_peak1"},   peak1,  12'h400);
        check_val({tag, "_overrun"}, 12'(overrun), 12'h0);
        check_val({tag, "_alarm"},   12'(alarm),   12'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [11:0] exp_pk;
        rst = 1'b1; tlm_ready = 1'b0;
        ain0 = 12'h800; ain1 = 12'h400; ain2 = 12'h200; ain3 = 12'h100;
        thr_hi = 12'hC00; thr_lo = 12'hA00;

        // Scenario 1: reset state and first-sample preload
        reset_dut();
        check_reset_outputs("s1");
        check_preload("s1");
        ack();
        check_val("s1_valid_drop", 12'(tlm_valid), 12'h0);

        // Scenario 2: EMA step response on ch0 (K=3)
        ain0 = 12'h000;
        wait_snap(n);
        check_val("s2_avg0_r1", avg0, 12'h700);
        check_val("s2_avg1_r1", avg1, 12'h400);
        ack();
        wait_snap(n);
        check_val("s2_avg0_r2", avg0, 12'h620);
        ack();

        // Scenario 3: alarm set, hold inside hysteresis band, clear
        ain2 = 12'hD00;
        for (int r = 1; r <= 18; r++) begin
            wait_snap(n);
            if (r == 17) begin
                check_val("s3_avg2_r17",  avg2, 12'hBDD);
                check_val("s3_alarm_r17", 12'(alarm), 12'h0);
            end
            if (r == 18) begin
                check_val("s3_avg2_r18",  avg2, 12'hC01);
                check_val("s3_alarm_r18", 12'(alarm), 12'h1);
            end
            ack();
        end
        ain2 = 12'hB00;
        for (int r = 1; r <= 3; r++) begin
            wait_snap(n);
            if (r == 1) check_val("s3_avg2_band", avg2, 12'hBE1);
            check_val("s3_alarm_hold", 12'(alarm), 12'h1);
            ack();
        end
        ain2 = 12'h900;
        for (int r = 1; r <= 8; r++) begin
            wait_snap(n);
            if (r == 7) begin
                check_val("s3_avg2_c7",  avg2, 12'hA0D);
                check_val("s3_alarm_c7", 12'(alarm), 12'h1);
            end
            if (r == 8) begin
                check_val("s3_avg2_c8",  avg2, 12'h9EB);
                check_val("s3_alarm_c8", 12'(alarm), 12'h0);
            end
            if (r < 8) ack();
        end

        // Scenario 6: reset while the FSM is in CH2, then preload again
        ain0 = 12'h800; ain1 = 12'h400; ain2 = 12'h200; ain3 = 12'h100;
        cyc(13);
        reset_dut();
        check_reset_outputs("s6");
        check_preload("s6");

        // Scenario 4: snapshot held across two dropped rounds, overrun sticky
        ain0 = 12'h000;
        cyc(40);
        check_val("s4_valid_held", 12'(tlm_valid), 12'h1);
        check_val("s4_avg0_held",  avg0, 12'h800);
        check_val("s4_avg1_held",  avg1, 12'h400);
        check_val("s4_overrun",    12'(overrun), 12'h1);
        ack();
        check_val("s4_valid_drop",   12'(tlm_valid), 12'h0);
        check_val("s4_overrun_stay", 12'(overrun),   12'h1);

        // Scenario 5: peak hold of a one-sample pulse, clear coinciding with CH0
        ain0 = 12'h100;
        reset_dut();
        check_val("s5_rst_overrun", 12'(overrun), 12'h0);
        wait_snap(n);
        check_val("s5_avg0_r1", avg0, 12'h100);
        ack();
        ain0 = 12'hFFF;
        wait_snap(n);
`ifdef SLOW_ADC_TELEMETRY_PEAK_EN
        exp_pk = 12'hFFF;
`else
        exp_pk = 12'h2DF;
`endif
        check_val("s5_avg0_r2",  avg0,  12'h2DF);
        check_val("s5_peak0_r2", peak0, exp_pk);
        ain0 = 12'h100;
        cyc(27);
        ack();
        wait_snap(n);
`ifdef SLOW_ADC_TELEMETRY_PEAK_EN
        exp_pk = 12'h100;
`else
        exp_pk = 12'h26F;
`endif
        check_val("s5_avg0_r4",  avg0,  12'h26F);
        check_val("s5_peak0_r4", peak0, exp_pk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slow_adc_telemetry.md
Name: slow_adc_telemetry

Overview:
- Downstream consumer of the four 12-bit slow-ADC channel registers (ain0..ain3) refreshed by the I2C ADC poller.
- Samples all four channels at a fixed rate and smooths each with an exponential moving average (EMA).
- Tracks peak-hold on channels 0/1 (forward/reverse power) and raises a hysteretic over-threshold alarm on channel 2 (PA temperature).
- Presents a coherent snapshot over a valid/ready handshake to the protocol-1 telemetry packer.

Parameters:
- SAMPLE_DIV, 1536: clk cycles between sample ticks; legal range ≥ 8.
- AVG_SHIFT, 3: EMA shift K; legal range 1..6.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ain0  in  12  ADC channel 0 (forward power)
- ain1  in  12  ADC channel 1 (reverse power)
- ain2  in  12  ADC channel 2 (temperature)
- ain3  in  12  ADC channel 3 (supply current)
- thr_hi  in  12  alarm set threshold, channel 2
- thr_lo  in  12  alarm clear threshold, channel 2
- avg0..avg3  out  12 each  EMA outputs of the snapshot
- peak0  out  12  snapshot peak, channel 0
- peak1  out  12  snapshot peak, channel 1
- alarm  out  1  channel-2 over-threshold flag, live
- tlm_valid  out  1  snapshot available
- tlm_ready  in  1  consumer accepts snapshot; also clears peak trackers
- overrun  out  1  sticky: a snapshot was dropped; cleared by reset only

Behaviour:
- Reset: all outputs 0; accumulators 0; primed=0; tick counter 0; state IDLE.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick=1 for one cycle when count = SAMPLE_DIV-1.
  - On tick, ain0..ain3 are captured into shadow registers in the same cycle, so all channels come from one instant.
- FSM states: IDLE, CH0, CH1, CH2, CH3, SNAP. One cycle per state with one shared EMA datapath.
  - IDLE -> CH0 on tick.
  - CHn -> CHn+1; CH3 -> SNAP; SNAP -> IDLE.
  - A tick arriving outside IDLE cannot occur, because SAMPLE_DIV ≥ 8.
- EMA in CHn, per channel:
  - Accumulator acc is 12+K bits, unsigned.
  - Normal update: acc <= acc - (acc>>K) + s, where s is the shadow sample. No overflow is possible.
  - avg_n = acc[11+K:K].
  - If primed=0, acc <= s<<K instead (first-sample preload).
  - primed is set in SNAP of the first round.
- Peak trackers (channels 0/1):
  - In CH0/CH1: pk <= max(pk, s).
  - On a tlm_valid && tlm_ready handshake, pk <= 0. If the clear and an update land in the same cycle, the update wins with pk <= s.
- Alarm, evaluated in CH2 on the new avg2:
  - Set when avg2 ≥ thr_hi.
  - Clear when avg2 ≤ thr_lo.
  - Otherwise hold.
  - If thr_lo ≥ thr_hi, the set condition has priority.
- SNAP:
  - If tlm_valid=0, or tlm_ready=1 in this cycle: load avg0..3, peak0/1 into the output registers and set tlm_valid=1 on the next cycle.
  - Otherwise keep the old snapshot untouched and set overrun=1.
- Handshake:
  - tlm_valid stays high until a cycle with tlm_ready=1, then drops the next cycle unless SNAP reloads it in that same cycle.
  - Outputs are stable while tlm_valid=1 and tlm_ready=0.
- Latency: tick in cycle t gives tlm_valid=1 in cycle t+6.
- Reset mid-round: the round is abandoned, primed=0, and the next tick restarts from IDLE with a preload.

Optional Feature:
- Macro: SLOW_ADC_TELEMETRY_PEAK_EN.
- Defined: peak trackers exist as described above.
- Undefined: no peak registers; peak0/peak1 equal the snapshot avg0/avg1; the handshake performs no clear.

Test Plan:
1. Reset, then ain0..3 = 0x800/0x400/0x200/0x100 and first tick -> t+6: tlm_valid=1, avg0..3 = 0x800/0x400/0x200/0x100 (preload), peak0=0x800, peak1=0x400.
2. After priming with ain0=0x800 (K=3), step ain0 to 0x000 -> next snapshot avg0=0x700, following snapshot 0x620.
3. thr_hi=0xC00, thr_lo=0xA00; ramp ain2 steady 0xD00 -> alarm=1 once avg2 ≥ 0xC00; drop ain2 to 0xB00 -> alarm stays 1; drop to 0x900 -> alarm clears once avg2 ≤ 0xA00.
4. Hold tlm_ready=0 across two rounds -> first snapshot held unchanged, overrun=1; then assert tlm_ready -> tlm_valid drops next cycle.
5. Pulse ain0 to 0xFFF for one sample then 0x100, with no handshake in between -> peak0=0xFFF; after a handshake the next snapshot peak0=0x100.
6. Assert rst in state CH2 -> all outputs 0; next tick reproduces the preload values of scenario 1.
